// File: rtl/pe_noc_endpoint.sv
// pe_noc_endpoint: PE-side NoC endpoint.
//
// The RX path accepts 64-bit packets from the router.
// - A kernel packet (type 01) addressed to this node loads the 40-bit
//   weight register.
// - An ifmap packet (type 00) addressed to this node pushes its 25-bit
//   spike row into a small first-word-fall-through FIFO.
// - Every other packet is consumed and dropped.
//
// The TX path packs the PE's output spikes and end-of-timestep markers
// into output packets addressed to the memory interface.
//
// The two paths are independent.
//
// Optional feature: define PE_NOC_EP_STATS_EN to build a saturating
// 16-bit dropped-packet counter on drop_cnt. Without it, drop_cnt is
// tied to zero.
//
// TX FSM states:
//   state | meaning
//   IDLE  | waiting for a spike or done request; spike has priority
//   SEND  | registered packet on tx_data, held until tx_ready

module pe_noc_endpoint #(
   parameter logic [3:0] NODE_ADDR  = 4'b0001,
   parameter logic [3:0] MEM_ADDR   = 4'b0000,
   parameter int         WIDTH_NOC  = 64,
   parameter int         FIFO_DEPTH = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 rx_valid,
   output logic                 rx_ready,
   input  logic [WIDTH_NOC-1:0] rx_data,
   output logic [39:0]          weights,
   output logic                 weight_valid,
   output logic                 ifmap_valid,
   input  logic                 ifmap_ready,
   output logic [24:0]          ifmap_row,
   input  logic                 spike_valid,
   output logic                 spike_ready,
   input  logic [4:0]           spike_row,
   input  logic [4:0]           spike_col,
   input  logic                 done_valid,
   output logic                 done_ready,
   output logic                 tx_valid,
   input  logic                 tx_ready,
   output logic [WIDTH_NOC-1:0] tx_data,
   output logic [15:0]          drop_cnt
);

   localparam int         AW          = $clog2(FIFO_DEPTH);
   localparam logic [AW:0] FULL_CNT   = (AW+1)'(FIFO_DEPTH);
   localparam int         PAD_W       = WIDTH_NOC - 20;
   localparam logic [1:0] TYPE_IFMAP  = 2'b00;
   localparam logic [1:0] TYPE_KERNEL = 2'b01;
   localparam logic [1:0] TYPE_OUTPUT = 2'b11;
   localparam logic [0:0] ST_IDLE     = 1'b0;
   localparam logic [0:0] ST_SEND     = 1'b1;

   // ---------------- RX decode ----------------
   logic       rx_fire;
   logic       rx_hit;
   logic [1:0] rx_type;
   logic       rx_kernel;
   logic       rx_ifmap;
   logic       fifo_full;
   logic       fifo_empty;

   // Source address and padding are never looked at.
   logic unused_rx;
   assign unused_rx = ^{rx_data[59:56], rx_data[53:40]};

   assign rx_type   = rx_data[55:54];
   assign rx_hit    = (rx_data[63:60] == NODE_ADDR);
   assign rx_ready  = !reset && !fifo_full;
   assign rx_fire   = rx_valid && rx_ready;
   assign rx_kernel = rx_fire && rx_hit && (rx_type == TYPE_KERNEL);
   assign rx_ifmap  = rx_fire && rx_hit && (rx_type == TYPE_IFMAP);

   // ---------------- weight register ----------------
   logic [39:0] weights_q, weights_d;
   logic        weight_valid_q, weight_valid_d;

   // Kernel reload overwrites immediately, independent of FIFO contents.
   always_comb begin
      weights_d      = weights_q;
      weight_valid_d = weight_valid_q;
      if (rx_kernel) begin
         weights_d      = rx_data[39:0];
         weight_valid_d = 1'b1;
      end
   end

   // Weight register flops.
   always_ff @(posedge clk) begin
      if (reset) begin
         weights_q      <= '0;
         weight_valid_q <= 1'b0;
      end else begin
         weights_q      <= weights_d;
         weight_valid_q <= weight_valid_d;
      end
   end

   assign weights      = weights_q;
   assign weight_valid = weight_valid_q;

   // ---------------- ifmap FIFO ----------------
   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   logic [AW:0] wr_ptr_q, wr_ptr_d;
   logic [AW:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0] fifo_cnt;
   logic [24:0] mem_q [FIFO_DEPTH];
   logic [24:0] mem_d [FIFO_DEPTH];
   logic        fifo_pop;

   assign fifo_cnt    = wr_ptr_q - rd_ptr_q;
   assign fifo_full   = (fifo_cnt == FULL_CNT);
   assign fifo_empty  = (wr_ptr_q == rd_ptr_q);
   assign ifmap_valid = !fifo_empty;
   assign fifo_pop    = ifmap_valid && ifmap_ready;
   // Head is forced to zero when empty so stale rows are never visible.
   assign ifmap_row   = fifo_empty ? 25'd0 : mem_q[rd_ptr_q[AW-1:0]];

   // Push and pop pointer and storage update.
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (rx_ifmap) begin
         mem_d[wr_ptr_q[AW-1:0]] = rx_data[24:0];
         wr_ptr_d                = wr_ptr_q + 1'b1;
      end
      if (fifo_pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
   end

   // FIFO pointer flops. Reset empties the FIFO.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // FIFO storage. The contents are qualified by the pointers, so there is no reset.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   // ---------------- TX FSM ----------------
   logic [0:0]           state_q, state_d;
   logic [WIDTH_NOC-1:0] tx_data_q, tx_data_d;
   logic [9:0]           hdr;

   assign hdr = {MEM_ADDR, NODE_ADDR, TYPE_OUTPUT};

   // Handshakes and next-state logic. A spike beats a simultaneous done, so
   // the done marker always trails every spike the PE has already issued.
   always_comb begin
      state_d     = state_q;
      tx_data_d   = tx_data_q;
      spike_ready = 1'b0;
      done_ready  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            spike_ready = !reset;
            done_ready  = !reset && !spike_valid;
            if (spike_valid && spike_ready) begin
               tx_data_d = {hdr, {PAD_W{1'b0}}, spike_row, spike_col};
               state_d   = ST_SEND;
            end else if (done_valid && done_ready) begin
               tx_data_d = {hdr, {PAD_W{1'b0}}, 10'h1FF};
               state_d   = ST_SEND;
            end
         end
         ST_SEND: begin
            if (tx_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // TX FSM and packet register flops.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         tx_data_q <= '0;
      end else begin
         state_q   <= state_d;
         tx_data_q <= tx_data_d;
      end
   end

   assign tx_valid = (state_q == ST_SEND);
   assign tx_data  = tx_data_q;

   // ---------------- drop statistics ----------------
`ifdef PE_NOC_EP_STATS_EN
   logic        rx_drop;
   logic [15:0] drop_cnt_q, drop_cnt_d;

   assign rx_drop = rx_fire && !(rx_kernel || rx_ifmap);

   // Saturating count of consumed-but-discarded packets.
   always_comb begin
      drop_cnt_d = drop_cnt_q;
      if (rx_drop && (drop_cnt_q != 16'hFFFF)) begin
         drop_cnt_d = drop_cnt_q + 16'd1;
      end
   end

   // Drop counter flop.
   always_ff @(posedge clk) begin
      if (reset) begin
         drop_cnt_q <= '0;
      end else begin
         drop_cnt_q <= drop_cnt_d;
      end
   end

   assign drop_cnt = drop_cnt_q;
`else
   assign drop_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_pe_noc_endpoint.sv
// Directed testbench for pe_noc_endpoint with hand-computed expectations.
module tb_pe_noc_endpoint;

   logic        clk = 1'b0;
   logic        reset;
   logic        rx_valid;
   logic        rx_ready;
   logic [63:0] rx_data;
   logic [39:0] weights;
   logic        weight_valid;
   logic        ifmap_valid;
   logic        ifmap_ready;
   logic [24:0] ifmap_row;
   logic        spike_valid;
   logic        spike_ready;
   logic [4:0]  spike_row;
   logic [4:0]  spike_col;
   logic        done_valid;
   logic        done_ready;
   logic        tx_valid;
   logic        tx_ready;
   logic [63:0] tx_data;
   logic [15:0] drop_cnt;

   int checks   = 0;
   int failures = 0;

   pe_noc_endpoint dut (
      .clk          (clk),
      .reset        (reset),
      .rx_valid     (rx_valid),
      .rx_ready     (rx_ready),
      .rx_data      (rx_data),
      .weights      (weights),
      .weight_valid (weight_valid),
      .ifmap_valid  (ifmap_valid),
      .ifmap_ready  (ifmap_ready),
      .ifmap_row    (ifmap_row),
      .spike_valid  (spike_valid),
      .spike_ready  (spike_ready),
      .spike_row    (spike_row),
      .spike_col    (spike_col),
      .done_valid   (done_valid),
      .done_ready   (done_ready),
      .tx_valid     (tx_valid),
      .tx_ready     (tx_ready),
      .tx_data      (tx_data),
      .drop_cnt     (drop_cnt)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tick(); tick(); tick();
      checks++;
      if ({rx_ready, weight_valid, ifmap_valid, spike_ready, done_ready, tx_valid} !== 6'b0) begin
         failures++;
         $display("FAIL reset_flags got=%b exp=000000",
                  {rx_ready, weight_valid, ifmap_valid, spike_ready, done_ready, tx_valid});
      end
      checks++;
      if ({weights, ifmap_row, tx_data, drop_cnt} !== '0) begin
         failures++;
         $display("FAIL reset_data weights=%h row=%h tx=%h drop=%0d exp=all zero",
                  weights, ifmap_row, tx_data, drop_cnt);
      end
      reset = 1'b0;
      #1;
      checks++;
      if (rx_ready !== 1'b1 || spike_ready !== 1'b1) begin
         failures++;
         $display("FAIL post_reset_ready rx_ready=%b spike_ready=%b exp=1 1", rx_ready, spike_ready);
      end
      tick();
   endtask

   task automatic test_kernel();
      rx_data  = 64'h1040_00AA_BBCC_DDEE;
      rx_valid = 1'b1;
      #1;
      checks++;
      if (weight_valid !== 1'b0) begin
         failures++;
         $display("FAIL kernel_pre got=%b exp=0", weight_valid);
      end
      tick();
      rx_valid = 1'b0;
      checks++;
      if (weights !== 40'hAA_BBCC_DDEE || weight_valid !== 1'b1) begin
         failures++;
         $display("FAIL kernel_load got=%h/%b exp=aabbccddee/1", weights, weight_valid);
      end
   endtask

   task automatic test_fifo_backpressure();
      logic [24:0] exp_row [5];
      ifmap_ready = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         rx_data  = {4'h1, 4'h0, 2'b00, 29'd0, 25'(i)};
         rx_valid = 1'b1;
         tick();
         if (i == 1) begin
            checks++;
            if (ifmap_valid !== 1'b1 || ifmap_row !== 25'd1) begin
               failures++;
               $display("FAIL fifo_first got=%b/%h exp=1/1", ifmap_valid, ifmap_row);
            end
         end
      end
      rx_data = {4'h1, 4'h0, 2'b00, 29'd0, 25'd5};
      tick();
      checks++;
      if (rx_ready !== 1'b0) begin
         failures++;
         $display("FAIL fifo_full_ready got=%b exp=0", rx_ready);
      end
      for (int k = 0; k < 5; k++) exp_row[k] = 25'(k + 1);
      ifmap_ready = 1'b1;
      for (int k = 0; k < 5; k++) begin
         #1;
         checks++;
         if (ifmap_valid !== 1'b1 || ifmap_row !== exp_row[k]) begin
            failures++;
            $display("FAIL fifo_pop%0d got=%b/%h exp=1/%h", k, ifmap_valid, ifmap_row, exp_row[k]);
         end
         if (k == 0) begin
            checks++;
            if (rx_ready !== 1'b0) begin
               failures++;
               $display("FAIL fifo_full_pop_ready got=%b exp=0", rx_ready);
            end
         end
         if (k == 1) begin
            checks++;
            if (rx_ready !== 1'b1) begin
               failures++;
               $display("FAIL fifo_reopen_ready got=%b exp=1", rx_ready);
            end
         end
         tick();
         if (k == 1) rx_valid = 1'b0;
      end
      checks++;
      if (ifmap_valid !== 1'b0) begin
         failures++;
         $display("FAIL fifo_drained got=%b exp=0", ifmap_valid);
      end
      ifmap_ready = 1'b0;
   endtask

   task automatic test_misroute();
      logic [15:0] exp_drop;
`ifdef PE_NOC_EP_STATS_EN
      exp_drop = 16'd2;
`else
      exp_drop = 16'd0;
`endif
      rx_data  = 64'h5000_0000_0000_0001;
      rx_valid = 1'b1;
      #1;
      checks++;
      if (rx_ready !== 1'b1) begin
         failures++;
         $display("FAIL misroute_ready got=%b exp=1", rx_ready);
      end
      tick();
      rx_data = 64'h10C0_0000_0000_0002;
      tick();
      rx_valid = 1'b0;
      checks++;
      if (ifmap_valid !== 1'b0 || weights !== 40'hAA_BBCC_DDEE) begin
         failures++;
         $display("FAIL misroute_state ifmap_valid=%b weights=%h exp=0/aabbccddee", ifmap_valid, weights);
      end
      checks++;
      if (drop_cnt !== exp_drop) begin
         failures++;
         $display("FAIL misroute_drop got=%0d exp=%0d", drop_cnt, exp_drop);
      end
   endtask

   task automatic test_spike_done_priority();
      spike_row   = 5'd3;
      spike_col   = 5'd7;
      spike_valid = 1'b1;
      done_valid  = 1'b1;
      tx_ready    = 1'b1;
      #1;
      checks++;
      if (spike_ready !== 1'b1 || done_ready !== 1'b0) begin
         failures++;
         $display("FAIL prio_ready spike=%b done=%b exp=1 0", spike_ready, done_ready);
      end
      tick();
      spike_valid = 1'b0;
      #1;
      checks++;
      if (tx_valid !== 1'b1 || tx_data !== 64'h01C0_0000_0000_0067) begin
         failures++;
         $display("FAIL prio_spike_pkt got=%b/%h exp=1/01c0000000000067", tx_valid, tx_data);
      end
      tick();
      checks++;
      if (tx_valid !== 1'b0 || done_ready !== 1'b1) begin
         failures++;
         $display("FAIL prio_idle tx_valid=%b done_ready=%b exp=0 1", tx_valid, done_ready);
      end
      tick();
      done_valid = 1'b0;
      #1;
      checks++;
      if (tx_valid !== 1'b1 || tx_data !== 64'h01C0_0000_0000_01FF) begin
         failures++;
         $display("FAIL prio_done_pkt got=%b/%h exp=1/01c00000000001ff", tx_valid, tx_data);
      end
      tick();
      tx_ready = 1'b0;
      #1;
      checks++;
      if (tx_valid !== 1'b0) begin
         failures++;
         $display("FAIL prio_end got=%b exp=0", tx_valid);
      end
   endtask

   task automatic test_tx_stall();
      tx_ready    = 1'b0;
      spike_row   = 5'd10;
      spike_col   = 5'd5;
      spike_valid = 1'b1;
      tick();
      spike_valid = 1'b0;
      for (int c = 0; c < 10; c++) begin
         #1;
         checks++;
         if (tx_valid !== 1'b1 || tx_data !== 64'h01C0_0000_0000_0145 || spike_ready !== 1'b0) begin
            failures++;
            $display("FAIL stall_c%0d got=%b/%h/%b exp=1/01c0000000000145/0",
                     c, tx_valid, tx_data, spike_ready);
         end
         tick();
      end
      tx_ready = 1'b1;
      tick();
      tx_ready = 1'b0;
      #1;
      checks++;
      if (tx_valid !== 1'b0 || spike_ready !== 1'b1) begin
         failures++;
         $display("FAIL stall_release tx_valid=%b spike_ready=%b exp=0 1", tx_valid, spike_ready);
      end
   endtask

   task automatic test_reset_mid();
      ifmap_ready = 1'b0;
      rx_valid    = 1'b1;
      rx_data     = {4'h1, 4'h0, 2'b00, 29'd0, 25'h1AA_AAAA};
      tick();
      rx_data     = {4'h1, 4'h0, 2'b00, 29'd0, 25'h055_5555};
      tick();
      rx_valid    = 1'b0;
      tx_ready    = 1'b0;
      spike_row   = 5'd1;
      spike_col   = 5'd2;
      spike_valid = 1'b1;
      tick();
      spike_valid = 1'b0;
      #1;
      checks++;
      if (tx_valid !== 1'b1 || ifmap_row !== 25'h1AA_AAAA) begin
         failures++;
         $display("FAIL rstmid_pre tx_valid=%b row=%h exp=1/1aaaaaa", tx_valid, ifmap_row);
      end
      reset = 1'b1;
      tick();
      checks++;
      if ({rx_ready, weight_valid, ifmap_valid, spike_ready, done_ready, tx_valid} !== 6'b0
          || {weights, ifmap_row, tx_data, drop_cnt} !== '0) begin
         failures++;
         $display("FAIL rstmid_outputs flags=%b weights=%h row=%h tx=%h drop=%0d exp=all zero",
                  {rx_ready, weight_valid, ifmap_valid, spike_ready, done_ready, tx_valid},
                  weights, ifmap_row, tx_data, drop_cnt);
      end
      reset = 1'b0;
      tick();
      rx_valid = 1'b1;
      rx_data  = {4'h1, 4'h0, 2'b00, 29'd0, 25'h000_0123};
      tick();
      rx_valid = 1'b0;
      checks++;
      if (ifmap_valid !== 1'b1 || ifmap_row !== 25'h000_0123) begin
         failures++;
         $display("FAIL rstmid_new_row got=%b/%h exp=1/0000123", ifmap_valid, ifmap_row);
      end
      ifmap_ready = 1'b1;
      tick();
      ifmap_ready = 1'b0;
      checks++;
      if (ifmap_valid !== 1'b0) begin
         failures++;
         $display("FAIL rstmid_empty got=%b exp=0", ifmap_valid);
      end
   endtask

   initial begin
      reset       = 1'b1;
      rx_valid    = 1'b0;
      rx_data     = '0;
      ifmap_ready = 1'b0;
      spike_valid = 1'b0;
      spike_row   = '0;
      spike_col   = '0;
      done_valid  = 1'b0;
      tx_ready    = 1'b0;
      test_reset();
      test_kernel();
      test_fifo_backpressure();
      test_misroute();
      test_spike_done_priority();
      test_tx_stall();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
